// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl
// Packet-level receive controller that sits behind a UART byte receiver.
// It hunts for SYNC_BYTE, then collects LEN, CMD, LEN payload bytes and CHK.
// CHK is the XOR of LEN, CMD and every payload byte. A packet that checks
// out is held for the host until acknowledged. Faults are reported as
// one-cycle error pulses.
//
// Handshakes:
//   Receiver side: i_rx_done is a one-cycle strobe qualifying i_rx_byte.
//   Bytes cannot be back-pressured, so any strobe that arrives while a
//   packet is held is dropped and flagged on o_err_drop.
//   Host side: o_pkt_valid stays high until the host samples i_pkt_ack=1
//   on a clock edge. o_pkt_valid is low from the following cycle.
//   o_pkt_cmd and o_pkt_len stay stable while o_pkt_valid is high.
//
// Ports:
//   i_Clock, reset      clock; synchronous active-high reset
//   i_rx_done/i_rx_byte byte strobe and data from the UART receiver
//   o_pkt_valid         a validated packet is held
//   o_pkt_cmd/o_pkt_len command and payload length of the packet
//   i_rd_addr/o_rd_data payload read port, registered, 1-cycle latency
//   i_pkt_ack           host releases the held packet
//   o_busy              FSM is not idle
//   o_err_*             one-cycle fault pulses (chk, len, timeout, drop)
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 50000,
  localparam int        LEN_W        = $clog2(MAX_LEN + 1)
) (
  input  logic             i_Clock,
  input  logic             reset,
  input  logic             i_rx_done,
  input  logic [7:0]       i_rx_byte,
  output logic             o_pkt_valid,
  output logic [7:0]       o_pkt_cmd,
  output logic [LEN_W-1:0] o_pkt_len,
  input  logic [LEN_W-1:0] i_rd_addr,
  output logic [7:0]       o_rd_data,
  input  logic             i_pkt_ack,
  output logic             o_busy,
  output logic             o_err_chk,
  output logic             o_err_len,
  output logic             o_err_timeout,
  output logic             o_err_drop
);

  localparam int              TO_W   = $clog2(TIMEOUT_CLKS);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_CMD, S_PAYLOAD, S_CHK, S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       xor_q, xor_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             err_chk_q, err_chk_d;
  logic             err_len_q, err_len_d;
  logic             err_to_q, err_to_d;
  logic             err_drop_q, err_drop_d;
  logic             buf_we;
  logic             in_frame;

  // MAX_LEN+1 entries keep the index width exactly LEN_W. The top entry is
  // never written, and reads of it are masked by the length compare.
  logic [7:0] pbuf_q [MAX_LEN+1];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    xor_d      = xor_q;
    err_chk_d  = 1'b0;
    err_len_d  = 1'b0;
    err_to_d   = 1'b0;
    err_drop_d = 1'b0;
    buf_we     = 1'b0;

    in_frame = (state_q == S_LEN) || (state_q == S_CMD) ||
               (state_q == S_PAYLOAD) || (state_q == S_CHK);

    // The inter-byte timer only runs inside a frame and restarts on every strobe.
    if (!in_frame || i_rx_done) to_cnt_d = '0;
    else                        to_cnt_d = to_cnt_q + TO_W'(1);

    case (state_q)
      S_IDLE: begin
        if (i_rx_done && (i_rx_byte == SYNC_BYTE)) state_d = S_LEN;
      end
      S_LEN: begin
        if (i_rx_done) begin
          if ((i_rx_byte == 8'h00) || (i_rx_byte > 8'(MAX_LEN))) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = LEN_W'(i_rx_byte);
            xor_d   = i_rx_byte;
            state_d = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (i_rx_done) begin
          cmd_d   = i_rx_byte;
          xor_d   = xor_q ^ i_rx_byte;
          idx_d   = '0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (i_rx_done) begin
          buf_we = 1'b1;
          xor_d  = xor_q ^ i_rx_byte;
          idx_d  = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (i_rx_done) begin
          if (i_rx_byte == xor_q) begin
            state_d = S_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // A byte is dropped even when the ack releases the packet in the
        // same cycle. The next packet must start with a fresh SYNC.
        if (i_rx_done) err_drop_d = 1'b1;
        if (i_pkt_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Expiry only happens on a strobe-less cycle, so a byte arriving in the
    // final cycle is processed normally above.
    if (in_frame && !i_rx_done && (to_cnt_q == TO_MAX)) begin
      err_to_d = 1'b1;
      state_d  = S_IDLE;
      to_cnt_d = '0;
    end

    rd_data_d = (i_rd_addr < len_q) ? pbuf_q[i_rd_addr] : 8'h00;
  end

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cmd_q      <= '0;
      idx_q      <= '0;
      xor_q      <= '0;
      to_cnt_q   <= '0;
      rd_data_q  <= '0;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_to_q   <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      xor_q      <= xor_d;
      to_cnt_q   <= to_cnt_d;
      rd_data_q  <= rd_data_d;
      err_chk_q  <= err_chk_d;
      err_len_q  <= err_len_d;
      err_to_q   <= err_to_d;
      err_drop_q <= err_drop_d;
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge i_Clock) begin
    if (buf_we && !reset) pbuf_q[idx_q] <= i_rx_byte;
  end

  assign o_pkt_valid   = (state_q == S_HOLD);
  assign o_busy        = (state_q != S_IDLE);
  assign o_pkt_cmd     = cmd_q;
  assign o_pkt_len     = len_q;
  assign o_rd_data     = rd_data_q;
  assign o_err_chk     = err_chk_q;
  assign o_err_len     = err_len_q;
  assign o_err_timeout = err_to_q;
  assign o_err_drop    = err_drop_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Testbench for uart_rx_pkt_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against a frame-level reference model.
module tb_uart_rx_pkt_ctrl;

  localparam int         MAX_LEN = 16;
  localparam int         TO      = 100;
  localparam int         LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam logic [LEN_W-1:0] NA = 5'd31;   // idle read address (beyond any len)

  logic             i_Clock = 1'b0;
  logic             reset;
  logic             i_rx_done;
  logic [7:0]       i_rx_byte;
  logic             o_pkt_valid;
  logic [7:0]       o_pkt_cmd;
  logic [LEN_W-1:0] o_pkt_len;
  logic [LEN_W-1:0] i_rd_addr;
  logic [7:0]       o_rd_data;
  logic             i_pkt_ack;
  logic             o_busy;
  logic             o_err_chk, o_err_len, o_err_timeout, o_err_drop;
  logic [3:0]       errs;

  assign errs = {o_err_chk, o_err_len, o_err_timeout, o_err_drop};

  uart_rx_pkt_ctrl #(
    .SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TO)
  ) dut (
    .i_Clock(i_Clock), .reset(reset), .i_rx_done(i_rx_done), .i_rx_byte(i_rx_byte),
    .o_pkt_valid(o_pkt_valid), .o_pkt_cmd(o_pkt_cmd), .o_pkt_len(o_pkt_len),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .i_pkt_ack(i_pkt_ack),
    .o_busy(o_busy), .o_err_chk(o_err_chk), .o_err_len(o_err_len),
    .o_err_timeout(o_err_timeout), .o_err_drop(o_err_drop)
  );

  // ---------------- clock / reset ----------------
  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1ns after a rising edge; outputs are sampled at the same
  // point, so they reflect the edge that consumed the previous inputs.
  task automatic drive(input logic d, input logic [7:0] b, input logic a,
                       input logic [LEN_W-1:0] addr);
    i_rx_done = d; i_rx_byte = b; i_pkt_ack = a; i_rd_addr = addr;
    @(posedge i_Clock);
    #1;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, ".valid"}, o_pkt_valid, 0);
    check({tag, ".busy"},  o_busy, 0);
    check({tag, ".cmd"},   o_pkt_cmd, 0);
    check({tag, ".len"},   o_pkt_len, 0);
    check({tag, ".rd"},    o_rd_data, 0);
    check({tag, ".errs"},  errs, 0);
  endtask

  // ---------------- vector table ----------------
  // err = {chk, len, timeout, drop}
  typedef struct {
    logic             d;
    logic [7:0]       b;
    logic             a;
    logic [LEN_W-1:0] addr;
    logic             v;
    logic [7:0]       cmd;
    logic [LEN_W-1:0] len;
    logic [7:0]       rd;
    logic             busy;
    logic [3:0]       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic d, logic [7:0] b, logic a, logic [LEN_W-1:0] addr,
                              logic v, logic [7:0] cmd, logic [LEN_W-1:0] len,
                              logic [7:0] rd, logic busy, logic [3:0] err);
    vec_t r;
    r.d = d; r.b = b; r.a = a; r.addr = addr; r.v = v; r.cmd = cmd;
    r.len = len; r.rd = rd; r.busy = busy; r.err = err;
    return r;
  endfunction

  task automatic fill_table();
    // good packet A5 03 10 11 22 33 13, then reads and ack
    tbl.push_back(mk(1, 8'hA5, 0, NA, 0, 8'h00, 0, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h03, 0, NA, 0, 8'h00, 3, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h10, 0, NA, 0, 8'h10, 3, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h11, 0, NA, 0, 8'h10, 3, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h22, 0, NA, 0, 8'h10, 3, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h33, 0, NA, 0, 8'h10, 3, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h13, 0, NA, 1, 8'h10, 3, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(0, 8'h00, 0, 0,  1, 8'h10, 3, 8'h11, 1, 4'b0000));
    tbl.push_back(mk(0, 8'h00, 0, 1,  1, 8'h10, 3, 8'h22, 1, 4'b0000));
    tbl.push_back(mk(0, 8'h00, 0, 2,  1, 8'h10, 3, 8'h33, 1, 4'b0000));
    tbl.push_back(mk(0, 8'h00, 0, 3,  1, 8'h10, 3, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(0, 8'h00, 1, 0,  0, 8'h10, 3, 8'h11, 0, 4'b0000));
    tbl.push_back(mk(0, 8'h00, 0, NA, 0, 8'h10, 3, 8'h00, 0, 4'b0000));
    // garbage then packet 00 FF A5 01 20 44 65
    tbl.push_back(mk(1, 8'h00, 0, NA, 0, 8'h10, 3, 8'h00, 0, 4'b0000));
    tbl.push_back(mk(1, 8'hFF, 0, NA, 0, 8'h10, 3, 8'h00, 0, 4'b0000));
    tbl.push_back(mk(1, 8'hA5, 0, NA, 0, 8'h10, 3, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h01, 0, NA, 0, 8'h10, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h20, 0, NA, 0, 8'h20, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h44, 0, NA, 0, 8'h20, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h65, 0, NA, 1, 8'h20, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(0, 8'h00, 0, 0,  1, 8'h20, 1, 8'h44, 1, 4'b0000));
    tbl.push_back(mk(0, 8'h00, 0, 1,  1, 8'h20, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(0, 8'h00, 1, NA, 0, 8'h20, 1, 8'h00, 0, 4'b0000));
    // bad checksum A5 01 20 44 00
    tbl.push_back(mk(1, 8'hA5, 0, NA, 0, 8'h20, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h01, 0, NA, 0, 8'h20, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h20, 0, NA, 0, 8'h20, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h44, 0, NA, 0, 8'h20, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h00, 0, NA, 0, 8'h20, 1, 8'h00, 0, 4'b1000));
    tbl.push_back(mk(0, 8'h00, 0, NA, 0, 8'h20, 1, 8'h00, 0, 4'b0000));
    // length faults A5 00, A5 11, then good packet A5 02 30 55 66 01
    tbl.push_back(mk(1, 8'hA5, 0, NA, 0, 8'h20, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h00, 0, NA, 0, 8'h20, 1, 8'h00, 0, 4'b0100));
    tbl.push_back(mk(1, 8'hA5, 0, NA, 0, 8'h20, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h11, 0, NA, 0, 8'h20, 1, 8'h00, 0, 4'b0100));
    tbl.push_back(mk(1, 8'hA5, 0, NA, 0, 8'h20, 1, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h02, 0, NA, 0, 8'h20, 2, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h30, 0, NA, 0, 8'h30, 2, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h55, 0, NA, 0, 8'h30, 2, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h66, 0, NA, 0, 8'h30, 2, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(1, 8'h01, 0, NA, 1, 8'h30, 2, 8'h00, 1, 4'b0000));
    tbl.push_back(mk(0, 8'h00, 0, 1,  1, 8'h30, 2, 8'h66, 1, 4'b0000));
    tbl.push_back(mk(0, 8'h00, 1, NA, 0, 8'h30, 2, 8'h00, 0, 4'b0000));
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: the bytes of the frame in progress are kept in a queue
  // and judged once enough of them exist; no per-field state machine.
  logic [7:0]       frame_q[$];
  bit               m_held;
  logic [7:0]       m_cmd;
  logic [LEN_W-1:0] m_len;
  logic [7:0]       m_mem[MAX_LEN];
  bit               m_known[MAX_LEN];
  int               m_idle;
  logic             e_v, e_busy, e_rd_ok;
  logic [7:0]       e_rd;
  logic [3:0]       e_err;

  task automatic model_reset();
    frame_q.delete();
    m_held = 0; m_cmd = 0; m_len = 0; m_idle = 0;
    for (int i = 0; i < MAX_LEN; i++) m_known[i] = 0;
  endtask

  task automatic model_step(input logic d, input logic [7:0] b, input logic a,
                            input logic [LEN_W-1:0] addr);
    int n;
    logic [7:0] x;
    e_rd = 8'h00;
    e_rd_ok = 1'b1;
    if (addr < m_len) begin
      e_rd = m_mem[int'(addr)];
      e_rd_ok = m_known[int'(addr)];
    end
    e_err = 4'b0000;
    if (m_held) begin
      if (d) e_err[0] = 1'b1;
      if (a) m_held = 0;
    end else if (frame_q.size() == 0) begin
      if (d && b == SYNC) begin
        frame_q.push_back(b);
        m_idle = 0;
      end
    end else if (d) begin
      m_idle = 0;
      frame_q.push_back(b);
      n = frame_q.size();
      if (n == 2) begin
        if (b == 0 || b > MAX_LEN) begin
          e_err[2] = 1'b1;
          frame_q.delete();
        end else m_len = LEN_W'(b);
      end else if (n == 3) begin
        m_cmd = b;
      end else if (n < int'(frame_q[1]) + 4) begin
        m_mem[n-4] = b;
        m_known[n-4] = 1;
      end else begin
        x = 8'h00;
        for (int i = 1; i < n - 1; i++) x ^= frame_q[i];
        if (x == b) m_held = 1;
        else e_err[3] = 1'b1;
        frame_q.delete();
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        e_err[1] = 1'b1;
        frame_q.delete();
      end
    end
    e_v = m_held;
    e_busy = m_held || (frame_q.size() != 0);
  endtask

  // ---------------- random packet generator ----------------
  logic [7:0] tx_q[$];

  task automatic gen_packet();
    int kind, len, keep;
    logic [7:0] x, c, p;
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      tx_q.push_back(8'($urandom));
    end else if (kind == 1) begin
      tx_q.push_back(SYNC);
      tx_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
    end else begin
      len = $urandom_range(1, MAX_LEN);
      c = 8'($urandom);
      x = 8'(len) ^ c;
      tx_q.push_back(SYNC);
      tx_q.push_back(8'(len));
      tx_q.push_back(c);
      for (int i = 0; i < len; i++) begin
        p = 8'($urandom);
        x ^= p;
        tx_q.push_back(p);
      end
      if (kind == 2) x ^= 8'($urandom_range(1, 255));
      tx_q.push_back(x);
      if (kind == 3) begin
        // truncated frame: relies on a later long gap or on following bytes
        keep = $urandom_range(1, tx_q.size() - 1);
        while (tx_q.size() > keep) void'(tx_q.pop_back());
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int gap;
    logic d, a;
    logic [7:0] b;
    logic [LEN_W-1:0] addr;

    reset = 1'b1;
    i_rx_done = 1'b0; i_rx_byte = 8'h00; i_pkt_ack = 1'b0; i_rd_addr = '0;
    repeat (3) drive(0, 8'h00, 0, 0);
    check_idle_outs("reset");
    reset = 1'b0;

    // table-driven vectors
    fill_table();
    foreach (tbl[i]) begin
      drive(tbl[i].d, tbl[i].b, tbl[i].a, tbl[i].addr);
      check($sformatf("vec%0d.valid", i), o_pkt_valid, tbl[i].v);
      check($sformatf("vec%0d.cmd", i),   o_pkt_cmd,   tbl[i].cmd);
      check($sformatf("vec%0d.len", i),   o_pkt_len,   tbl[i].len);
      check($sformatf("vec%0d.rd", i),    o_rd_data,   tbl[i].rd);
      check($sformatf("vec%0d.busy", i),  o_busy,      tbl[i].busy);
      check($sformatf("vec%0d.errs", i),  errs,        tbl[i].err);
    end

    // timeout: A5 02 20 then silence; pulse on the 100th quiet cycle
    drive(1, 8'hA5, 0, NA); drive(1, 8'h02, 0, NA); drive(1, 8'h20, 0, NA);
    for (int i = 1; i < TO; i++) begin
      drive(0, 8'h00, 0, NA);
      check($sformatf("to_quiet%0d.errs", i), errs, 0);
    end
    drive(0, 8'h00, 0, NA);
    check("to_fire.errs", errs, 4'b0010);
    check("to_fire.busy", o_busy, 0);
    drive(0, 8'h00, 0, NA);
    check("to_after.errs", errs, 0);

    // a byte in the expiry cycle wins over the timeout
    drive(1, 8'hA5, 0, NA); drive(1, 8'h02, 0, NA); drive(1, 8'h20, 0, NA);
    for (int i = 1; i < TO; i++) drive(0, 8'h00, 0, NA);
    drive(1, 8'h77, 0, NA);
    check("to_save.errs", errs, 0);
    check("to_save.busy", o_busy, 1);
    drive(1, 8'h88, 0, NA);
    drive(1, 8'hDD, 0, NA);
    check("to_save.valid", o_pkt_valid, 1);
    check("to_save.len", o_pkt_len, 2);

    // drop while held: packet unchanged
    drive(1, SYNC, 0, NA);
    check("drop.errs", errs, 4'b0001);
    check("drop.valid", o_pkt_valid, 1);
    check("drop.cmd", o_pkt_cmd, 8'h20);
    check("drop.len", o_pkt_len, 2);
    drive(0, 8'h00, 0, 0);
    check("drop.rd0", o_rd_data, 8'h77);
    // ack coincident with a strobe: drop and release
    drive(1, 8'h5A, 1, NA);
    check("ackdrop.errs", errs, 4'b0001);
    check("ackdrop.valid", o_pkt_valid, 0);
    drive(0, 8'h00, 0, NA);
    check("ackdrop.busy", o_busy, 0);
    check("ackdrop.errs_after", errs, 0);

    // reset mid-payload
    drive(1, 8'hA5, 0, NA); drive(1, 8'h03, 0, NA); drive(1, 8'h40, 0, NA); drive(1, 8'h11, 0, NA);
    reset = 1'b1;
    drive(0, 8'h00, 0, 0);
    check_idle_outs("midrst");
    reset = 1'b0;
    drive(0, 8'h00, 0, 0);
    check_idle_outs("midrst_after");

    // randomized traffic against the reference model
    reset = 1'b1;
    drive(0, 8'h00, 0, NA);
    reset = 1'b0;
    model_reset();
    gap = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      d = 1'b0;
      b = 8'($urandom);
      if (gap > 0) gap--;
      else if (tx_q.size() == 0) gen_packet();
      else begin
        d = 1'b1;
        b = tx_q.pop_front();
        gap = ($urandom_range(0, 39) == 0) ? $urandom_range(TO - 5, TO + 5) : $urandom_range(0, 3);
      end
      a = (m_held && $urandom_range(0, 2) == 0) || ($urandom_range(0, 15) == 0);
      addr = LEN_W'($urandom_range(0, MAX_LEN + 1));
      model_step(d, b, a, addr);
      drive(d, b, a, addr);
      check($sformatf("rnd%0d.valid", cyc), o_pkt_valid, e_v);
      check($sformatf("rnd%0d.busy", cyc),  o_busy, e_busy);
      check($sformatf("rnd%0d.errs", cyc),  errs, e_err);
      check($sformatf("rnd%0d.cmd", cyc),   o_pkt_cmd, m_cmd);
      check($sformatf("rnd%0d.len", cyc),   o_pkt_len, m_len);
      if (e_rd_ok) check($sformatf("rnd%0d.rd", cyc), o_rd_data, e_rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
